// File: rtl/rv_test_monitor.sv
// End-of-test monitor: shadows the DONE/RESULT GPR writes, waits for DONE to hold
// PASS_VALUE, then grades RESULT into sticky pass/fail/timeout flags.
module rv_test_monitor #(
    parameter int unsigned        XLEN           = 32,
    parameter int unsigned        DONE_REG       = 26,
    parameter int unsigned        RESULT_REG     = 27,
    parameter logic [XLEN-1:0]    PASS_VALUE     = XLEN'(1),
    parameter int unsigned        STABLE_CYCLES  = 2,
    parameter int unsigned        TIMEOUT_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_waddr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    output logic            test_done_o,
    output logic            test_pass_o,
    output logic            test_fail_o,
    output logic            test_tmo_o,
    output logic [XLEN-1:0] result_o,
    output logic [31:0]     cycles_o
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StRun,
        StSettle,
        StPass,
        StFail,
        StTmo
    } state_e;

    state_e            r_state;
    logic [XLEN-1:0]   r_done_sh;
    logic [XLEN-1:0]   r_result_sh;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [31:0]       r_cyc;
    logic              r_done;
    logic              r_pass;
    logic              r_fail;
    logic              r_tmo;
    logic [XLEN-1:0]   r_result;

    logic              w_wr_valid;
    logic              w_done_hit;
    logic              w_result_hit;
    logic [XLEN-1:0]   w_done_next;
    logic [XLEN-1:0]   w_result_next;
    logic              w_active;
    logic [31:0]       w_cyc_next;

    // x0 is hardwired zero in the core, so writes to it never reach a shadow.
    assign w_wr_valid    = wb_we_i && (wb_waddr_i != 5'd0);
    assign w_done_hit    = w_wr_valid && (wb_waddr_i == 5'(DONE_REG));
    assign w_result_hit  = w_wr_valid && (wb_waddr_i == 5'(RESULT_REG));
    assign w_done_next   = w_done_hit ? wb_wdata_i : r_done_sh;
    assign w_result_next = w_result_hit ? wb_wdata_i : r_result_sh;
    assign w_active      = (r_state == StRun) || (r_state == StSettle);
    assign w_cyc_next    = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_done_sh   <= '0;
            r_result_sh <= '0;
            r_stab_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_cyc       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_tmo       <= 1'b0;
            r_result    <= '0;
        end else begin
            if (w_active) begin
                r_done_sh   <= w_done_next;
                r_result_sh <= w_result_next;
                r_cyc       <= w_cyc_next;
            end
            case (r_state)
                StRun: begin
                    // Timeout takes priority over a DONE write on the same edge.
                    if (r_tmo_cnt == TMO_LAST) begin
                        r_state <= StTmo;
                        r_tmo   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        if (w_done_next == PASS_VALUE) begin
                            r_state    <= StSettle;
                            r_stab_cnt <= STAB_W'(1);
                        end
                    end
                end
                StSettle: begin
                    if (w_done_next != PASS_VALUE) begin
                        r_state    <= StRun;
                        r_stab_cnt <= '0;
                    end else if (r_stab_cnt == STAB_LAST) begin
                        r_result <= w_result_next;
                        r_done   <= 1'b1;
                        if (w_result_next == PASS_VALUE) begin
                            r_state <= StPass;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= StFail;
                            r_fail  <= 1'b1;
                        end
                    end else begin
                        r_stab_cnt <= r_stab_cnt + STAB_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign test_done_o = r_done;
    assign test_pass_o = r_pass;
    assign test_fail_o = r_fail;
    assign test_tmo_o  = r_tmo;
    assign result_o    = r_result;
    assign cycles_o    = r_cyc;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor; cycle k is the period ending at the k-th
// posedge after reset release. Inputs change and outputs are sampled on negedges.
module tb_rv_test_monitor;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        test_done;
    logic        test_pass;
    logic        test_fail;
    logic        test_tmo;
    logic [31:0] result;
    logic [31:0] cycles;

    int n_vec;
    int n_err;
    int cyc;

    rv_test_monitor #(
        .XLEN          (32),
        .DONE_REG      (26),
        .RESULT_REG    (27),
        .PASS_VALUE    (32'd1),
        .STABLE_CYCLES (2),
        .TIMEOUT_CYCLES(50)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we_i    (wb_we),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata),
        .test_done_o(test_done),
        .test_pass_o(test_pass),
        .test_fail_o(test_fail),
        .test_tmo_o (test_tmo),
        .result_o   (result),
        .cycles_o   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_cycle(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge: exactly one reset edge, then release before edge 1.
    task automatic do_reset();
        rst_n    = 1'b0;
        wb_we    = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d, input logic en);
        wait_cycle(k);
        wb_we    = en;
        wb_waddr = a;
        wb_wdata = d;
        wait_cycle(k + 1);
        wb_we    = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_done"}, {31'd0, test_done}, 32'd0);
        check_val({tag, "_pass"}, {31'd0, test_pass}, 32'd0);
        check_val({tag, "_fail"}, {31'd0, test_fail}, 32'd0);
        check_val({tag, "_tmo"}, {31'd0, test_tmo}, 32'd0);
        check_val({tag, "_result"}, result, 32'd0);
        check_val({tag, "_cycles"}, cycles, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        do_reset();

        // Single write port: RESULT first, then DONE at cycle 20; grade on edge 22.
        check_idle("rst1");
        wr(19, 5'd27, 32'd1, 1'b1);
        wr(20, 5'd26, 32'd1, 1'b1);
        wait_cycle(22);
        check_val("s1_pass_early", {31'd0, test_pass}, 32'd0);
        wait_cycle(23);
        check_val("s1_pass", {31'd0, test_pass}, 32'd1);
        check_val("s1_done", {31'd0, test_done}, 32'd1);
        check_val("s1_tmo", {31'd0, test_tmo}, 32'd0);
        check_val("s1_result", result, 32'd1);
        check_val("s1_cycles", cycles, 32'd22);

        do_reset();
        check_idle("rst2");
        wr(5, 5'd27, 32'd0, 1'b1);
        wr(6, 5'd26, 32'd1, 1'b1);
        wait_cycle(9);
        check_val("s2_fail", {31'd0, test_fail}, 32'd1);
        check_val("s2_pass", {31'd0, test_pass}, 32'd0);
        check_val("s2_result", result, 32'd0);
        check_val("s2_cycles", cycles, 32'd8);

        // DONE drops during SETTLE; grading only after the cycle-30 window.
        do_reset();
        wr(5, 5'd27, 32'd1, 1'b1);
        wr(10, 5'd26, 32'd1, 1'b1);
        wr(11, 5'd26, 32'd0, 1'b1);
        wait_cycle(13);
        check_val("s3_abort_done", {31'd0, test_done}, 32'd0);
        wr(30, 5'd26, 32'd1, 1'b1);
        wait_cycle(32);
        check_val("s3_done_early", {31'd0, test_done}, 32'd0);
        wait_cycle(33);
        check_val("s3_pass", {31'd0, test_pass}, 32'd1);
        wait_cycle(40);
        check_val("s3_cycles_frozen", cycles, 32'd32);
        check_val("s3_pass_sticky", {31'd0, test_pass}, 32'd1);

        do_reset();
        wait_cycle(50);
        check_val("s4_tmo_early", {31'd0, test_tmo}, 32'd0);
        wait_cycle(51);
        check_val("s4_tmo", {31'd0, test_tmo}, 32'd1);
        check_val("s4_done", {31'd0, test_done}, 32'd1);
        check_val("s4_pass", {31'd0, test_pass}, 32'd0);
        check_val("s4_fail", {31'd0, test_fail}, 32'd0);
        check_val("s4_cycles", cycles, 32'd50);
        wait_cycle(60);
        check_val("s4_tmo_sticky", {31'd0, test_tmo}, 32'd1);
        check_val("s4_cycles_frozen", cycles, 32'd50);

        // Ignored writes must not enter SETTLE (which would freeze the timeout).
        do_reset();
        wr(9, 5'd27, 32'd1, 1'b1);
        wr(10, 5'd0, 32'd1, 1'b1);
        wr(11, 5'd26, 32'd1, 1'b0);
        wait_cycle(20);
        check_val("s5_done", {31'd0, test_done}, 32'd0);
        wait_cycle(51);
        check_val("s5_tmo", {31'd0, test_tmo}, 32'd1);
        check_val("s5_cycles", cycles, 32'd50);

        // RESULT written on the grading edge is bypassed into the grade.
        do_reset();
        wr(5, 5'd27, 32'd1, 1'b1);
        wr(10, 5'd26, 32'd1, 1'b1);
        wr(12, 5'd27, 32'd7, 1'b1);
        wait_cycle(13);
        check_val("byp_fail", {31'd0, test_fail}, 32'd1);
        check_val("byp_result", result, 32'd7);

        // Reset lands on what would have been the grading edge.
        do_reset();
        wr(5, 5'd27, 32'd1, 1'b1);
        wr(10, 5'd26, 32'd1, 1'b1);
        wait_cycle(12);
        check_val("s6_settle_done", {31'd0, test_done}, 32'd0);
        do_reset();
        check_idle("s6_rst");
        wait_cycle(6);
        check_val("s6_shadow_clear", {31'd0, test_done}, 32'd0);
        wr(19, 5'd27, 32'd1, 1'b1);
        wr(20, 5'd26, 32'd1, 1'b1);
        wait_cycle(23);
        check_val("s6_pass", {31'd0, test_pass}, 32'd1);
        check_val("s6_cycles", cycles, 32'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
